// File: rtl/button_event_gen.sv
// button_event_gen: turns a clean debounced button level into one-cycle
// press/release strobes, adds typematic auto-repeat, a long-press level and
// a wrapping 8-bit press counter. All outputs are registered.
module button_event_gen #(
    parameter int unsigned HOLD_DELAY    = 2500,
    parameter int unsigned REPEAT_PERIOD = 500,
    parameter int unsigned LONG_PRESS    = 10000,
    parameter int unsigned CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       debounced_button,
    input  logic       repeat_en,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       repeat_pulse,
    output logic       long_press,
    output logic       held,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_DELAY);
    localparam logic [CNT_W-1:0] REP_MAX  = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_PRESS);

    state_e           state_q;
    logic             btn_q;
    logic             armed_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] rep_cnt_q;
    logic [CNT_W-1:0] long_cnt_q;
    logic             press_pulse_q;
    logic             release_pulse_q;
    logic             repeat_pulse_q;
    logic             long_press_q;
    logic             held_q;
    logic [7:0]       press_count_q;

    logic press_evt;
    logic release_evt;
    logic hold_fire;
    logic rep_fire;

    // Edge and timer-expiry conditions evaluated on the current inputs.
    always_comb begin
        // NOTE: every signal driven here is assigned on every path, so no latch is inferred.
        press_evt   = (state_q == ST_IDLE) & armed_q & debounced_button & ~btn_q;
        release_evt = (state_q != ST_IDLE) & ~debounced_button & btn_q;
        hold_fire   = (state_q == ST_HOLD) & repeat_en & (hold_cnt_q == HOLD_MAX);
        rep_fire    = (state_q == ST_REPEAT) & repeat_en & (rep_cnt_q == REP_MAX);
    end

    // Event FSM: press/hold/repeat sequencing, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            btn_q           <= 1'b0;
            armed_q         <= 1'b0;
            hold_cnt_q      <= '0;
            rep_cnt_q       <= '0;
            long_cnt_q      <= '0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            repeat_pulse_q  <= 1'b0;
            long_press_q    <= 1'b0;
            held_q          <= 1'b0;
            press_count_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            btn_q <= debounced_button;
            // A button held through reset must be seen low once before any press counts.
            if (!debounced_button) begin
                armed_q <= 1'b1;
            end

            // Strobes default low; they are raised for exactly one cycle below.
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            repeat_pulse_q  <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (press_evt) begin
                        state_q       <= ST_HOLD;
                        press_pulse_q <= 1'b1;
                        held_q        <= 1'b1;
                        press_count_q <= press_count_q + 8'd1;
                        hold_cnt_q    <= CNT_ONE;
                        long_cnt_q    <= CNT_ONE;
                        rep_cnt_q     <= '0;
                    end
                end

                ST_HOLD, ST_REPEAT: begin
                    if (release_evt) begin
                        // Release takes priority over any repeat due on this edge.
                        state_q         <= ST_IDLE;
                        release_pulse_q <= 1'b1;
                        held_q          <= 1'b0;
                        long_press_q    <= 1'b0;
                        hold_cnt_q      <= '0;
                        rep_cnt_q       <= '0;
                        long_cnt_q      <= '0;
                    end else begin
                        // Long-press timer runs regardless of state or repeat_en.
                        if (long_cnt_q == LONG_MAX) begin
                            long_press_q <= 1'b1;
                        end else begin
                            long_cnt_q <= long_cnt_q + CNT_ONE;
                        end

                        if (state_q == ST_HOLD) begin
                            if (hold_fire) begin
                                state_q        <= ST_REPEAT;
                                repeat_pulse_q <= 1'b1;
                                rep_cnt_q      <= CNT_ONE;
                            end else if (hold_cnt_q != HOLD_MAX) begin
                                // Saturates at HOLD_DELAY while repeat is disabled.
                                hold_cnt_q <= hold_cnt_q + CNT_ONE;
                            end
                        end else begin
                            if (!repeat_en) begin
                                // Parked: on re-enable a full period elapses before the next pulse.
                                rep_cnt_q <= CNT_ONE;
                            end else if (rep_fire) begin
                                repeat_pulse_q <= 1'b1;
                                rep_cnt_q      <= CNT_ONE;
                            end else begin
                                rep_cnt_q <= rep_cnt_q + CNT_ONE;
                            end
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign repeat_pulse  = repeat_pulse_q;
    assign long_press    = long_press_q;
    assign held          = held_q;
    assign press_count   = press_count_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Scoreboard bench for button_event_gen: each stimulus step queues the
// events it must cause (kind, edge number, press count); a monitor pops and
// compares every observed strobe or level change.
module tb_button_event_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       debounced_button;
    logic       repeat_en;
    logic       press_pulse;
    logic       release_pulse;
    logic       repeat_pulse;
    logic       long_press;
    logic       held;
    logic [7:0] press_count;

    button_event_gen dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .debounced_button(debounced_button),
        .repeat_en       (repeat_en),
        .press_pulse     (press_pulse),
        .release_pulse   (release_pulse),
        .repeat_pulse    (repeat_pulse),
        .long_press      (long_press),
        .held            (held),
        .press_count     (press_count)
    );

    always #5 clk = ~clk;

    // Number of the most recent rising edge; read at negedges only.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {
        EV_PRESS, EV_RELEASE, EV_REPEAT, EV_LONG_RISE, EV_LONG_FALL, EV_HELD_RISE, EV_HELD_FALL
    } ev_kind_e;

    typedef struct {
        ev_kind_e kind;
        int       t;
        int       cnt;
    } ev_t;

    ev_t exp_q[$];
    int  tests   = 0;
    int  fails   = 0;
    int  exp_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input ev_kind_e k, input int t, input int c = 0);
        ev_t e;
        e.kind = k;
        e.t    = t;
        e.cnt  = c;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_e k);
        ev_t e;
        if (exp_q.size() == 0) begin
            check($sformatf("spurious_%s", k.name()), 1, 0);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("kind_of_%s", e.kind.name()), int'(k), int'(e.kind));
            check($sformatf("time_of_%s", e.kind.name()), cyc, e.t);
            if (k == EV_PRESS && e.kind == EV_PRESS)
                check("press_count", {24'd0, press_count}, e.cnt);
        end
    endtask

    // Monitor: turns DUT output activity into events, in a fixed per-cycle order.
    logic prev_held = 1'b0;
    logic prev_long = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_held = 1'b0;
            prev_long = 1'b0;
        end else begin
            if (press_pulse)              observe(EV_PRESS);
            if (release_pulse)            observe(EV_RELEASE);
            if (repeat_pulse)             observe(EV_REPEAT);
            if (long_press && !prev_long) observe(EV_LONG_RISE);
            if (!long_press && prev_long) observe(EV_LONG_FALL);
            if (held && !prev_held)       observe(EV_HELD_RISE);
            if (!held && prev_held)       observe(EV_HELD_FALL);
            prev_held = held;
            prev_long = long_press;
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Called at a negedge; the next rising edge is the press edge.
    task automatic press_at(output int p);
        debounced_button = 1'b1;
        p       = cyc + 1;
        exp_cnt = (exp_cnt + 1) % 256;
        push(EV_PRESS, p, exp_cnt);
        push(EV_HELD_RISE, p);
    endtask

    task automatic release_at(input int r, input bit long_on);
        wait_until(r - 1);
        debounced_button = 1'b0;
        push(EV_RELEASE, r);
        if (long_on) push(EV_LONG_FALL, r);
        push(EV_HELD_FALL, r);
    endtask

    task automatic gap_and_drain(input string tag);
        repeat (6) @(negedge clk);
        check({tag, "_queue_left"}, exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_press"},   press_pulse,   0);
        check({tag, "_release"}, release_pulse, 0);
        check({tag, "_repeat"},  repeat_pulse,  0);
        check({tag, "_long"},    long_press,    0);
        check({tag, "_held"},    held,          0);
        check({tag, "_count"},   press_count,   0);
    endtask

    initial begin
        int p;
        rst_n            = 1'b0;
        debounced_button = 1'b1;
        repeat_en        = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        // Button held through reset: no event until it has been seen low.
        rst_n = 1'b1;
        repeat (20000) @(negedge clk);
        check("held_thru_reset_count", press_count, 0);
        debounced_button = 1'b0;
        @(negedge clk);
        press_at(p);
        release_at(p + 1, 1'b0);
        gap_and_drain("arm_press");

        // 3200-cycle press with repeat: pulses at 2500 and 3000 only.
        repeat_en = 1'b1;
        press_at(p);
        push(EV_REPEAT, p + 2500);
        push(EV_REPEAT, p + 3000);
        release_at(p + 3200, 1'b0);
        gap_and_drain("repeat3200");

        // 12000-cycle press: long_press rises at 10000, falls on release.
        repeat_en = 1'b0;
        press_at(p);
        push(EV_LONG_RISE, p + 10000);
        release_at(p + 12000, 1'b1);
        gap_and_drain("long12000");

        // repeat_en enabled late: first pulse on the following edge.
        press_at(p);
        wait_until(p + 4000);
        repeat_en = 1'b1;
        push(EV_REPEAT, p + 4001);
        push(EV_REPEAT, p + 4501);
        release_at(p + 4700, 1'b0);
        gap_and_drain("late_enable");

        // Reset during REPEAT: everything clears at once, no release strobe.
        press_at(p);
        push(EV_REPEAT, p + 2500);
        wait_until(p + 2600);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        check("mid_reset_queue_left", exp_q.size(), 0);
        exp_cnt = 0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("rearm_needs_low_count", press_count, 0);
        check("rearm_needs_low_held", held, 0);
        debounced_button = 1'b0;
        @(negedge clk);

        // 256 one-cycle presses: press/release pairs, counter wraps to 0.
        for (int i = 0; i < 256; i++) begin
            press_at(p);
            @(negedge clk);
            debounced_button = 1'b0;
            push(EV_RELEASE, p + 1);
            push(EV_HELD_FALL, p + 1);
            repeat (2) @(negedge clk);
        end
        gap_and_drain("short256");
        check("wrap_count", press_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
